// File: rtl/regwrite_scoreboard.sv
// Register-write scoreboard: checks core RegWrite traffic against a FIFO of expected writes.
// Optional SCOREBOARD_ZERO_FILTER_EN ignores writes to register 0.
module regwrite_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       clear,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [ADDR_W-1:0]          exp_addr,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic                       RegWrite,
  input  logic [ADDR_W-1:0]          WriteReg,
  input  logic [DATA_W-1:0]          WriteData,
  output logic [CNT_W-1:0]           match_count,
  output logic [CNT_W-1:0]           err_count,
  output logic                       mismatch,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [1:0]                 state
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FAIL  = 2'd2,
    S_TOUT  = 2'd3
  } state_t;

  state_t            stateQ, stateD;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rdPtr, wrPtr;
  logic [LVL_W-1:0]  level, levelD;
  logic [TMR_W-1:0]  idleTmr;
  logic [CNT_W-1:0]  matchCnt, errCnt;
  logic              mismatchQ, failQ, toutQ;
  logic              full, empty, obsWrite;
  logic              push, pop, hit, err, timerHit;

  assign full  = level == LVL_W'(DEPTH);
  assign empty = level == '0;

`ifdef SCOREBOARD_ZERO_FILTER_EN
  assign obsWrite = RegWrite && (WriteReg != '0);
`else
  assign obsWrite = RegWrite;
`endif

  // push uses registered full, so a same-edge pop never frees a slot
  assign push   = exp_valid && !full;
  assign pop    = obsWrite && !empty;
  assign hit    = pop && (mem[rdPtr] == {WriteReg, WriteData});
  assign err    = obsWrite && !hit;
  assign levelD = level + LVL_W'(push) - LVL_W'(pop);

  assign timerHit = !obsWrite &&
    ((idleTmr + TMR_W'(1)) >= TMR_W'(TIMEOUT));

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      S_IDLE:
        if (levelD != '0) stateD = S_ARMED;
      S_ARMED:
        if (timerHit) stateD = S_TOUT;
        else if (levelD == '0) stateD = S_IDLE;
      default: stateD = stateQ;
    endcase
    if (err) stateD = S_FAIL;
  end

  always_ff @(posedge Clk) begin
    if (push && !clear && !Reset)
      mem[wrPtr] <= {exp_addr, exp_data};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      level     <= '0;
      idleTmr   <= '0;
      matchCnt  <= '0;
      errCnt    <= '0;
      mismatchQ <= 1'b0;
      failQ     <= 1'b0;
      toutQ     <= 1'b0;
      stateQ    <= S_IDLE;
    end else if (clear) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      level     <= '0;
      idleTmr   <= '0;
      matchCnt  <= '0;
      errCnt    <= '0;
      mismatchQ <= 1'b0;
      failQ     <= 1'b0;
      toutQ     <= 1'b0;
      stateQ    <= S_IDLE;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      level <= levelD;
      if (hit && matchCnt != '1)
        matchCnt <= matchCnt + CNT_W'(1);
      if (err && errCnt != '1)
        errCnt <= errCnt + CNT_W'(1);
      mismatchQ <= err;
      stateQ    <= stateD;
      failQ     <= stateD == S_FAIL;
      if (stateD == S_TOUT) toutQ <= 1'b1;
      // timer only runs while staying in ARMED without a write
      if (stateQ == S_ARMED && stateD == S_ARMED && !obsWrite)
        idleTmr <= idleTmr + TMR_W'(1);
      else
        idleTmr <= '0;
    end
  end

  assign exp_ready   = !full;
  assign match_count = matchCnt;
  assign err_count   = errCnt;
  assign mismatch    = mismatchQ;
  assign fail        = failQ;
  assign timeout     = toutQ;
  assign fifo_level  = level;
  assign state       = stateQ;

endmodule

// File: tb/tb_regwrite_scoreboard.sv
// Bench for regwrite_scoreboard: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_regwrite_scoreboard;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int CMAX    = (1 << CNT_W) - 1;

  typedef logic [ADDR_W+DATA_W-1:0] ent_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              clear = 1'b0;
  logic              exp_valid = 1'b0;
  logic              exp_ready;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              RegWrite = 1'b0;
  logic [ADDR_W-1:0] WriteReg = '0;
  logic [DATA_W-1:0] WriteData = '0;
  logic [CNT_W-1:0]  match_count, err_count;
  logic              mismatch, fail, timeout;
  logic [LVL_W-1:0]  fifo_level;
  logic [1:0]        state;

  always #5 Clk = ~Clk;

  regwrite_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData),
    .match_count(match_count), .err_count(err_count),
    .mismatch(mismatch), .fail(fail), .timeout(timeout),
    .fifo_level(fifo_level), .state(state)
  );

  // reference model
  ent_t mq[$];
  int   mMatch, mErr, mState, mIdle;
  bit   mMm, mTout;
  int   nComp, nErr;

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic mReset();
    mq.delete();
    mMatch = 0;
    mErr   = 0;
    mState = 0;
    mIdle  = 0;
    mMm    = 0;
    mTout  = 0;
  endtask

  task automatic modelStep();
    bit   wr, pushOk, err;
    ent_t h;
    if (clear) begin
      mReset();
      return;
    end
    pushOk = exp_valid && (mq.size() < DEPTH);
    wr = RegWrite;
`ifdef SCOREBOARD_ZERO_FILTER_EN
    if (WriteReg == '0) wr = 0;
`endif
    err = 0;
    if (wr) begin
      if (mq.size() == 0) err = 1;
      else begin
        h = mq.pop_front();
        if (h == {WriteReg, WriteData}) mMatch = sat(mMatch + 1);
        else err = 1;
      end
    end
    if (pushOk) mq.push_back({exp_addr, exp_data});
    mMm = err;
    if (err) begin
      mErr = sat(mErr + 1);
      mState = 2;
      mIdle = 0;
    end else if (mState == 0 && mq.size() > 0) begin
      mState = 1;
    end else if (mState == 1) begin
      mIdle = wr ? 0 : mIdle + 1;
      if (mIdle >= TIMEOUT) begin
        mState = 3;
        mIdle = 0;
      end else if (mq.size() == 0) begin
        mState = 0;
        mIdle = 0;
      end
    end
    if (mState == 3) mTout = 1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    nComp++;
    assert (got === want) else begin
      nErr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic checkAll(string tag);
    chk({tag, ".match_count"}, 32'(match_count), mMatch);
    chk({tag, ".err_count"}, 32'(err_count), mErr);
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(mMm));
    chk({tag, ".fail"}, 32'(fail), 32'(mState == 2));
    chk({tag, ".timeout"}, 32'(timeout), 32'(mTout));
    chk({tag, ".fifo_level"}, 32'(fifo_level), mq.size());
    chk({tag, ".state"}, 32'(state), mState);
    chk({tag, ".exp_ready"}, 32'(exp_ready), 32'(mq.size() != DEPTH));
  endtask

  task automatic cycle(string tag);
    modelStep();
    @(posedge Clk);
    #1;
    checkAll(tag);
  endtask

  task automatic step(string tag,
                      bit pv, logic [ADDR_W-1:0] pa, logic [DATA_W-1:0] pd,
                      bit rw, logic [ADDR_W-1:0] ra, logic [DATA_W-1:0] rd);
    exp_valid = pv;
    exp_addr  = pa;
    exp_data  = pd;
    RegWrite  = rw;
    WriteReg  = ra;
    WriteData = rd;
    cycle(tag);
    exp_valid = 1'b0;
    RegWrite  = 1'b0;
  endtask

  task automatic idle(string tag);
    step(tag, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic clearCycle();
    clear = 1'b1;
    cycle("clear");
    clear = 1'b0;
  endtask

  // write that matches the model's queue head
  task automatic writeHead(string tag, bit pv, logic [ADDR_W-1:0] pa,
                           logic [DATA_W-1:0] pd);
    ent_t h;
    h = mq[0];
    step(tag, pv, pa, pd, 1, h[ADDR_W+DATA_W-1:DATA_W], h[DATA_W-1:0]);
  endtask

  initial begin
    nComp = 0;
    nErr  = 0;
    mReset();
    #12;
    checkAll("reset");
    Reset = 1'b0;

    step("t1p", 1, 5'd8, 32'd5, 0, '0, '0);
    step("t1p", 1, 5'd9, 32'd7, 0, '0, '0);
    step("t1p", 1, 5'd10, 32'd12, 0, '0, '0);
    step("t1w", 0, '0, '0, 1, 5'd8, 32'd5);
    step("t1w", 0, '0, '0, 1, 5'd9, 32'd7);
    step("t1w", 0, '0, '0, 1, 5'd10, 32'd12);
    chk("t1.match", 32'(match_count), 3);
    chk("t1.err", 32'(err_count), 0);
    chk("t1.state", 32'(state), 0);
    clearCycle();

    step("t2p", 1, 5'd10, 32'd12, 0, '0, '0);
    step("t2w", 0, '0, '0, 1, 5'd10, 32'd13);
    chk("t2.mismatch", 32'(mismatch), 1);
    chk("t2.fail", 32'(fail), 1);
    idle("t2i");
    chk("t2.pulse_end", 32'(mismatch), 0);
    chk("t2.state", 32'(state), 2);
    clearCycle();

    step("t3w", 0, '0, '0, 1, 5'd11, 32'd4);
    chk("t3.err", 32'(err_count), 1);
    chk("t3.level", 32'(fifo_level), 0);
    clearCycle();

    for (int i = 0; i < DEPTH; i++)
      step("t4fill", 1, ADDR_W'(i + 1), $urandom, 0, '0, '0);
    chk("t4.ready", 32'(exp_ready), 0);
    writeHead("t4full", 1, 5'd20, 32'd20);
    chk("t4.refused", 32'(fifo_level), DEPTH - 1);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (mq.size() >= DEPTH - 1 || $urandom_range(0, 1) == 1)
        writeHead("t4wrap", 1, ADDR_W'($urandom), $urandom);
      else
        step("t4wrap", 1, ADDR_W'($urandom), $urandom, 0, '0, '0);
    end
    for (int i = 0; i < DEPTH && mq.size() > 0; i++)
      writeHead("t4drain", 0, '0, '0);
    chk("t4.match_sat", 32'(match_count), CMAX);
    chk("t4.err", 32'(err_count), 0);
    chk("t4.state", 32'(state), 0);
    clearCycle();

    step("t5p", 1, 5'd3, 32'd3, 0, '0, '0);
    repeat (TIMEOUT + 2) idle("t5i");
    chk("t5.timeout", 32'(timeout), 1);
    chk("t5.state", 32'(state), 3);
    step("t5w", 0, '0, '0, 1, 5'd3, 32'd4);
    chk("t5.fail_state", 32'(state), 2);
    chk("t5.timeout_sticky", 32'(timeout), 1);
    clearCycle();

    repeat (CMAX + 4) step("t6", 0, '0, '0, 1, 5'd11, 32'd4);
    chk("t6.err_sat", 32'(err_count), CMAX);
    clearCycle();

    step("t7", 0, '0, '0, 1, 5'd0, 32'd99);
`ifdef SCOREBOARD_ZERO_FILTER_EN
    chk("t7.zero_filtered", 32'(err_count), 0);
`else
    chk("t7.zero_checked", 32'(err_count), 1);
`endif
    clearCycle();

    for (int i = 0; i < 400; i++) begin
      bit pv, rw;
      ent_t h;
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      clear = ($urandom_range(0, 49) == 0);
      pv = ($urandom_range(0, 9) < 6);
      rw = ($urandom_range(0, 1) == 1);
      ra = ADDR_W'($urandom);
      rd = DATA_W'($urandom_range(0, 15));
      if (rw && mq.size() > 0 && $urandom_range(0, 7) != 0) begin
        h  = mq[0];
        ra = h[ADDR_W+DATA_W-1:DATA_W];
        rd = h[DATA_W-1:0];
      end
      step("rnd", pv, ADDR_W'($urandom), DATA_W'($urandom_range(0, 15)),
           rw, ra, rd);
      clear = 1'b0;
    end

    clearCycle();
    step("t9p", 1, 5'd1, 32'd1, 0, '0, '0);
    step("t9w", 0, '0, '0, 1, 5'd2, 32'd2);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    mReset();
    checkAll("async_reset");
    chk("t9.state", 32'(state), 0);
    #3;
    Reset = 1'b0;
    idle("t9post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nErr);
    $finish;
  end

endmodule
